mem_port_arbiter: RTL and testbench

- Shares the single byte-addressed 1 KB data memory between two requesters: the instruction-fetch port (I, read-only) and the MEM-stage data port (D, read/write).
- Drives the memory's memRead/memWrite/addr/wd and captures rd.
- Round-robin arbitration; req/ack handshake per port.
- Rejects misaligned or out-of-range word accesses without touching memory.

---
 rtl/mem_port_arbiter_pkg.sv | 9 +
 rtl/mem_port_arbiter_if.sv | 29 ++
 rtl/mem_port_arbiter_addr_check.sv | 11 +
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared widths, FSM encoding and port ids for the memory port arbiter.
package mem_port_arbiter_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MEM_BYTES_DEF = 1024;
  typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2, ACK = 2'd3} state_t;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshakes plus the memory bus; master = requesters/memory, slave = arbiter.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;
  logic i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic i_ack;
  logic i_err;
  logic d_req;
  logic d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic d_ack;
  logic d_err;
  logic mem_read;
  logic mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
    input i_rdata, i_ack, i_err, d_rdata, d_ack, d_err, mem_read, mem_write, mem_addr, mem_wd
  );
  modport slave (
    input i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
    output i_rdata, i_ack, i_err, d_rdata, d_ack, d_err, mem_read, mem_write, mem_addr, mem_wd
  );
endinterface

// File: rtl/mem_port_arbiter_addr_check.sv
// mem_addr_check: flags word accesses that are misaligned or run past the end of memory.
module mem_addr_check
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              illegal
);
  assign illegal = (|addr[1:0]) || (addr > ADDR_W'(MEM_BYTES - 4));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one data memory between the fetch (I) and MEM-stage (D) ports.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
);
  state_t state_q, state_d;
  logic last_q, last_d, port_q, port_d, we_q, we_d;
  logic i_ack_q, i_ack_d, d_ack_q, d_ack_d, i_err_q, i_err_d, d_err_q, d_err_d;
  logic [ADDR_W-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, mem_wd_q, mem_wd_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d, rd_val;
  logic illegal, gnt, go, rd, wr, pick_d;
  mem_addr_check #(.MEM_BYTES(MEM_BYTES)) u_chk (.addr(addr_q), .illegal(illegal));
  assign gnt = (state_q == GNT_I) || (state_q == GNT_D);
  assign go = gnt && !illegal;
  assign rd = go && !we_q;
  assign wr = go && we_q;
  assign rd_val = rd ? bus.mem_rd : '0;
  // D wins unless it was the last port served while I is also waiting
  assign pick_d = bus.d_req && (!bus.i_req || last_q == PORT_I);
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    port_d = port_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d = mem_wd_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_d = 1'b0;
    d_ack_d = 1'b0;
    i_err_d = 1'b0;
    d_err_d = 1'b0;
    case (state_q)
      IDLE: if (bus.i_req || bus.d_req) begin
        state_d = pick_d ? GNT_D : GNT_I;
        port_d = pick_d ? PORT_D : PORT_I;
        last_d = pick_d ? PORT_D : PORT_I;
        addr_d = pick_d ? bus.d_addr : bus.i_addr;
        we_d = pick_d && bus.d_we;
        wdata_d = pick_d ? bus.d_wdata : wdata_q;
      end
      GNT_I, GNT_D: begin
        state_d = ACK;
        mem_addr_d = go ? addr_q : mem_addr_q;
        mem_wd_d = wr ? wdata_q : mem_wd_q;
        i_ack_d = port_q == PORT_I;
        d_ack_d = port_q == PORT_D;
        i_err_d = (port_q == PORT_I) && illegal;
        d_err_d = (port_q == PORT_D) && illegal;
        i_rdata_d = (port_q == PORT_I) ? rd_val : i_rdata_q;
        d_rdata_d = (port_q == PORT_D) ? rd_val : d_rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q <= PORT_I;
      port_q <= PORT_I;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      mem_addr_q <= '0;
      mem_wd_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      i_err_q <= 1'b0;
      d_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      port_q <= port_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q <= mem_wd_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q <= i_ack_d;
      d_ack_q <= d_ack_d;
      i_err_q <= i_err_d;
      d_err_q <= d_err_d;
    end
  end
  assign bus.mem_read = rd;
  assign bus.mem_write = wr;
  assign bus.mem_addr = go ? addr_q : mem_addr_q;
  assign bus.mem_wd = wr ? wdata_q : mem_wd_q;
  assign bus.i_ack = i_ack_q;
  assign bus.d_ack = d_ack_q;
  assign bus.i_err = i_err_q;
  assign bus.d_err = d_err_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors plus hand sequences against a byte-array memory model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;
  typedef struct {
    logic port;
    logic we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic err;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic booted = 1'b0;
  logic [7:0] mem [1024];
  int n_chk = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  vec_t v [12];
  mem_port_arbiter_if bus ();
  mem_port_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // memory preloads bytes 0..7 with their own index, zero elsewhere
  always @(posedge clk) begin
    if (!booted) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i < 8 ? i : 0);
      booted <= 1'b1;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr[9:0]] <= bus.mem_wd[7:0];
      mem[bus.mem_addr[9:0] + 10'd1] <= bus.mem_wd[15:8];
      mem[bus.mem_addr[9:0] + 10'd2] <= bus.mem_wd[23:16];
      mem[bus.mem_addr[9:0] + 10'd3] <= bus.mem_wd[31:24];
    end
    if (bus.mem_write) wr_cnt <= wr_cnt + 1;
    if (bus.mem_read) rd_cnt <= rd_cnt + 1;
  end
  always_comb
    bus.mem_rd = (bus.mem_addr <= 32'd1020) ?
      {mem[bus.mem_addr[9:0] + 10'd3], mem[bus.mem_addr[9:0] + 10'd2],
       mem[bus.mem_addr[9:0] + 10'd1], mem[bus.mem_addr[9:0]]} : 32'h0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic access(input string nm, input vec_t t);
    int lat = 0;
    int w0 = wr_cnt;
    int r0 = rd_cnt;
    logic got = 1'b0;
    if (t.port) begin
      bus.d_req = 1'b1; bus.d_we = t.we; bus.d_addr = t.addr; bus.d_wdata = t.wdata;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = t.addr;
    end
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      got = t.port ? bus.d_ack : bus.i_ack;
    end
    check({nm, " latency"}, lat, 2);
    check({nm, " rdata"}, t.port ? bus.d_rdata : bus.i_rdata, t.rdata);
    check({nm, " err"}, 32'(t.port ? bus.d_err : bus.i_err), 32'(t.err));
    check({nm, " other ack"}, 32'(t.port ? bus.i_ack : bus.d_ack), 0);
    @(negedge clk);
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;
    check({nm, " writes"}, wr_cnt - w0, 32'(t.we && !t.err));
    check({nm, " reads"}, rd_cnt - r0, 32'(!t.we && !t.err));
  endtask
  initial begin
    int dc, ic, n, w0;
    logic [31:0] dd, id;
    logic ord [8];
    int cyc [8];
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int dc, ic, n, w0;
    logic [31:0] dd, id;
    logic ord [8];
    int cyc [8];
    v[0]  = '{1'b1, 1'b1, 32'd8,    32'hDEADBEEF, 32'h0,        1'b0};
    v[1]  = '{1'b1, 1'b0, 32'd8,    32'h0,        32'hDEADBEEF, 1'b0};
    v[2]  = '{1'b0, 1'b0, 32'd0,    32'h0,        32'h03020100, 1'b0};
    v[3]  = '{1'b1, 1'b1, 32'd6,    32'hAAAAAAAA, 32'h0,        1'b1};
    v[4]  = '{1'b0, 1'b0, 32'd1024, 32'h0,        32'h0,        1'b1};
    v[5]  = '{1'b1, 1'b0, 32'd4,    32'h0,        32'h07060504, 1'b0};
    v[6]  = '{1'b1, 1'b1, 32'd1020, 32'hCAFEF00D, 32'h0,        1'b0};
    v[7]  = '{1'b0, 1'b0, 32'd1020, 32'h0,        32'hCAFEF00D, 1'b0};
    v[8]  = '{1'b1, 1'b0, 32'd1021, 32'h0,        32'h0,        1'b1};
    v[9]  = '{1'b0, 1'b0, 32'd4,    32'h0,        32'h07060504, 1'b0};
    v[10] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'h0,        1'b1};
    v[11] = '{1'b0, 1'b0, 32'd2,    32'h0,        32'h0,        1'b1};
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst i_ack", 32'(bus.i_ack), 0);
    check("rst d_ack", 32'(bus.d_ack), 0);
    check("rst errs", 32'({bus.i_err, bus.d_err}), 0);
    check("rst i_rdata", bus.i_rdata, 0);
    check("rst d_rdata", bus.d_rdata, 0);
    check("rst mem rw", 32'({bus.mem_read, bus.mem_write}), 0);
    check("rst mem_addr", bus.mem_addr, 0);
    check("rst mem_wd", bus.mem_wd, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) access($sformatf("v%0d", i), v[i]);
    // both requests raised together with reset release
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 32'd0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'd8;
    dc = 0; ic = 0; dd = '0; id = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.d_ack) begin dc = k; dd = bus.d_rdata; end
      if (bus.i_ack) begin ic = k; id = bus.i_rdata; end
      if (dc != 0 && k == dc + 1) bus.d_req = 1'b0;
      if (ic != 0 && k == ic + 1) bus.i_req = 1'b0;
    end
    check("sim d cycle", dc, 2);
    check("sim d rdata", dd, 32'hDEADBEEF);
    check("sim i cycle", ic, 5);
    check("sim i rdata", id, 32'h03020100);
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'd0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'd4;
    n = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.d_ack && bus.i_ack) check("cont dual ack", 1, 0);
      if ((bus.d_ack || bus.i_ack) && n < 8) begin ord[n] = bus.d_ack; cyc[n] = k; n++; end
      if (bus.d_ack) check("cont d rdata", bus.d_rdata, 32'h07060504);
      if (bus.i_ack) check("cont i rdata", bus.i_rdata, 32'h03020100);
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    check("cont ack count", n, 4);
    for (int j = 0; j < 4 && j < n; j++) begin
      check($sformatf("cont order %0d", j), 32'(ord[j]), 32'(j % 2 == 0));
      check($sformatf("cont cycle %0d", j), cyc[j], 2 + 3 * j);
    end
    @(negedge clk);
    w0 = wr_cnt;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'd16; bus.d_wdata = 32'h12345678;
    @(negedge clk);
    check("rstmid mem_write", 32'(bus.mem_write), 1);
    check("rstmid mem_addr", bus.mem_addr, 32'd16);
    rst_n = 1'b0;
    @(negedge clk);
    bus.d_req = 1'b0;
    check("rstmid d_ack", 32'(bus.d_ack), 0);
    check("rstmid mem_addr0", bus.mem_addr, 0);
    check("rstmid mem_wd0", bus.mem_wd, 0);
    check("rstmid mem rw", 32'({bus.mem_read, bus.mem_write}), 0);
    check("rstmid committed", wr_cnt - w0, 1);
    @(negedge clk);
    check("rstmid no ack", 32'({bus.i_ack, bus.d_ack}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    access("rstmid rd", '{1'b1, 1'b0, 32'd16, 32'h0, 32'h12345678, 1'b0});
    w0 = wr_cnt;
    access("held wr", '{1'b1, 1'b1, 32'd12, 32'h55AA55AA, 32'h0, 1'b0});
    access("held idle", '{1'b0, 1'b0, 32'd12, 32'h0, 32'h55AA55AA, 1'b0});
    check("held one write", wr_cnt - w0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
